// File: rtl/simmem_pkg.sv
// rtl/simmem_pkg.sv - shared simulated-memory constants, types and row helpers
package simmem_pkg;

  localparam int AxAddrWidth    = 20;
  localparam int AxLenWidth     = 8;
  localparam int RowBufLenW     = 10;
  localparam int RowIdWidth     = AxAddrWidth - RowBufLenW;
  localparam int WRspBankAddrW  = 4;
  localparam int RDataBankAddrW = 5;
  localparam int IidW = (WRspBankAddrW > RDataBankAddrW) ? WRspBankAddrW : RDataBankAddrW;
  localparam int StatW = 16;

  localparam int RowHitCost     = 10;
  localparam int PrechargeCost  = 50;
  localparam int ActivationCost = 45;

  // Worst case is a conflict plus the longest burst; sized so the counter never wraps.
  localparam int CntW = $clog2(PrechargeCost + ActivationCost + RowHitCost + (2 ** AxLenWidth));

  typedef enum logic {
    WRSP_BANK  = 1'b0,
    RDATA_BANK = 1'b1
  } rsp_bank_type_e;

  typedef enum logic [1:0] {
    ROW_HIT,
    ROW_CLOSED,
    ROW_CONFLICT
  } row_access_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_RELEASE
  } row_timer_state_e;

  function automatic logic [RowIdWidth-1:0] get_row_id(input logic [AxAddrWidth-1:0] addr);
    return RowIdWidth'(addr >> RowBufLenW);
  endfunction

endpackage

// File: rtl/simmem_row_classifier.sv
// rtl/simmem_row_classifier.sv - classifies an access against the open row and computes its delay
module simmem_row_classifier
  import simmem_pkg::*;
(
  input  logic                   row_open_i,
  input  logic [RowIdWidth-1:0]  open_row_i,
  input  logic [AxAddrWidth-1:0] addr_i,
  input  logic [AxLenWidth-1:0]  burst_len_i,
  output row_access_e            access_o,
  output logic [RowIdWidth-1:0]  row_id_o,
  output logic [CntW-1:0]        delay_o
);

  localparam logic [CntW-1:0] HitCost      = CntW'(RowHitCost);
  localparam logic [CntW-1:0] ClosedCost   = CntW'(ActivationCost + RowHitCost);
  localparam logic [CntW-1:0] ConflictCost = CntW'(PrechargeCost + ActivationCost + RowHitCost);

  logic [CntW-1:0] row_cost;

  always_comb begin
    row_id_o = get_row_id(addr_i);
    access_o = ROW_CLOSED;
    row_cost = ClosedCost;
    if (row_open_i) begin
      if (open_row_i == row_id_o) begin
        access_o = ROW_HIT;
        row_cost = HitCost;
      end else begin
        access_o = ROW_CONFLICT;
        row_cost = ConflictCost;
      end
    end
    delay_o = row_cost + CntW'(burst_len_i);
  end

endmodule

// File: rtl/simmem_row_delay_timer.sv
// rtl/simmem_row_delay_timer.sv - single-bank open-page DRAM delay model releasing one id at a time
// Optional build macro SIMMEM_ROW_STATS_EN adds saturating per-class access counters.
module simmem_row_delay_timer
  import simmem_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  rsp_bank_type_e         req_bank_i,
  input  logic [IidW-1:0]        req_iid_i,
  input  logic [AxAddrWidth-1:0] req_addr_i,
  input  logic [AxLenWidth-1:0]  req_burst_len_i,
  output logic                   rel_valid_o,
  input  logic                   rel_ready_i,
  output rsp_bank_type_e         rel_bank_o,
  output logic [IidW-1:0]        rel_iid_o
`ifdef SIMMEM_ROW_STATS_EN
  ,
  output logic [StatW-1:0]       stat_hits_o,
  output logic [StatW-1:0]       stat_closed_o,
  output logic [StatW-1:0]       stat_conflicts_o
`endif
);

  row_timer_state_e      state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  row_open_q;
  logic [RowIdWidth-1:0] open_row_q;
  rsp_bank_type_e        rel_bank_q;
  logic [IidW-1:0]       rel_iid_q;

  row_access_e           access;
  logic [RowIdWidth-1:0] row_id;
  logic [CntW-1:0]       delay;
  logic                  accept;

  simmem_row_classifier u_classifier (
    .row_open_i  (row_open_q),
    .open_row_i  (open_row_q),
    .addr_i      (req_addr_i),
    .burst_len_i (req_burst_len_i),
    .access_o    (access),
    .row_id_o    (row_id),
    .delay_o     (delay)
  );

  assign req_ready_o = (state_q == ST_IDLE);
  assign rel_valid_o = (state_q == ST_RELEASE);
  assign accept      = req_valid_i && req_ready_o;
  assign rel_bank_o  = rel_bank_q;
  assign rel_iid_o   = rel_iid_q;

  // Loading D-1 and moving to RELEASE on the edge after zero gives exactly D cycles to rel_valid.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_COUNT;
          cnt_d   = delay - CntW'(1);
        end
      end
      ST_COUNT: begin
        if (cnt_q == '0) begin
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      ST_RELEASE: begin
        if (rel_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      rel_bank_q <= WRSP_BANK;
      rel_iid_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        row_open_q <= 1'b1;
        open_row_q <= row_id;
        rel_bank_q <= req_bank_i;
        rel_iid_q  <= req_iid_i;
      end
    end
  end

`ifdef SIMMEM_ROW_STATS_EN
  logic [StatW-1:0] hits_q, closed_q, conflicts_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hits_q      <= '0;
      closed_q    <= '0;
      conflicts_q <= '0;
    end else if (accept) begin
      if (access == ROW_HIT && hits_q != '1) hits_q <= hits_q + StatW'(1);
      if (access == ROW_CLOSED && closed_q != '1) closed_q <= closed_q + StatW'(1);
      if (access == ROW_CONFLICT && conflicts_q != '1) conflicts_q <= conflicts_q + StatW'(1);
    end
  end

  assign stat_hits_o      = hits_q;
  assign stat_closed_o    = closed_q;
  assign stat_conflicts_o = conflicts_q;
`else
  logic unused_access;
  assign unused_access = ^access;
`endif

endmodule
